// File: rtl/bus_dma_pkg.sv
// Shared types and bus map for the block-copy bus initiator.
package bus_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        FIN
    } dma_state_t;

    // Word addresses on the shared CPU data bus
    localparam int unsigned RAM_TOP   = 32'h0000_0080;
    localparam int unsigned PORT_ADDR = 32'h0000_0081;
    localparam int unsigned PIN_ADDR  = 32'h0000_0082;

endpackage

// File: rtl/bus_dma_copy.sv
// Bus initiator copying len words from src_addr to dst_addr, one read and one write per word.
module bus_dma_copy
    import bus_dma_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic [CNT_W-1:0] len,
    input  logic             irq_clr,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [WIDTH-1:0] addr,
    output logic             we,
    output logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] rd,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic [CNT_W-1:0] words_left
);

    dma_state_t       r_state;
    logic [WIDTH-1:0] r_src;
    logic [WIDTH-1:0] r_dst;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_words_left;
    logic             r_abort;
    logic             r_bus_req;
    logic             r_busy;
    logic             r_done;
    logic             r_irq;
    logic             w_in_write;

    // Write strobe follows the grant combinationally so it can never fire while another master owns the bus
    assign w_in_write = (r_state == WRITE);
    assign we         = w_in_write & bus_gnt;

    assign addr       = r_addr;
    assign wd         = r_data;
    assign bus_req    = r_bus_req;
    assign busy       = r_busy;
    assign done       = r_done;
    assign irq        = r_irq;
    assign words_left = r_words_left;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_words_left <= '0;
            r_abort      <= 1'b0;
            r_bus_req    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A clear never beats the completion that is being flagged right now
            if (irq_clr && (r_state != FIN)) begin
                r_irq <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src        <= src_addr;
                        r_dst        <= dst_addr;
                        r_words_left <= len;
                        r_abort      <= 1'b0;
                        r_busy       <= 1'b1;
                        if (len == '0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_irq   <= 1'b1;
                        end else begin
                            r_state   <= REQ;
                            r_bus_req <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (abort) begin
                        r_state   <= FIN;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_irq     <= 1'b1;
                    end else if (bus_gnt) begin
                        r_state <= READ;
                        r_addr  <= r_src;
                    end
                end

                READ: begin
                    // Abort is remembered so the word in flight still completes its write
                    if (abort) begin
                        r_abort <= 1'b1;
                    end
                    if (bus_gnt) begin
                        r_data  <= rd;
                        r_addr  <= r_dst;
                        r_state <= WRITE;
                    end
                end

                WRITE: begin
                    if (abort) begin
                        r_abort <= 1'b1;
                    end
                    if (bus_gnt) begin
                        r_src        <= r_src + WIDTH'(1);
                        r_dst        <= r_dst + WIDTH'(1);
                        r_words_left <= r_words_left - CNT_W'(1);
                        if ((r_words_left == CNT_W'(1)) || abort || r_abort) begin
                            r_state   <= FIN;
                            r_bus_req <= 1'b0;
                            r_done    <= 1'b1;
                            r_irq     <= 1'b1;
                        end else begin
                            r_state <= READ;
                            r_addr  <= r_src + WIDTH'(1);
                        end
                    end
                end

                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma_copy.sv
// Scoreboard bench for bus_dma_copy: directed corner cases plus randomized copies under random grant.
module tb_bus_dma_copy;
    import bus_dma_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [W-1:0]  src_addr;
    logic [W-1:0]  dst_addr;
    logic [CW-1:0] len;
    logic          irq_clr;
    logic          bus_req;
    logic          bus_gnt;
    logic [W-1:0]  addr;
    logic          we;
    logic [W-1:0]  wd;
    logic [W-1:0]  rd;
    logic          busy;
    logic          done;
    logic          irq;
    logic [CW-1:0] words_left;

    bus_dma_copy #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .irq_clr   (irq_clr),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .addr      (addr),
        .we        (we),
        .wd        (wd),
        .rd        (rd),
        .busy      (busy),
        .done      (done),
        .irq       (irq),
        .words_left(words_left)
    );

    always #5 clk = ~clk;

    // Bus slave: 256-word space aliased on addr[7:0]; PORT/PIN simply live in that space
    logic [W-1:0] mem       [256];
    logic [W-1:0] model_mem [256];

    assign rd = mem[addr[7:0]];

    always @(posedge clk) begin
        if (we) mem[addr[7:0]] <= wd;
    end

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    wr_t           exp_q[$];
    logic [CW-1:0] done_q[$];
    int            errors = 0;
    int            checks = 0;
    bit            sb_off = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [W-1:0] d);
        mem[a]       = d;
        model_mem[a] = d;
    endtask

    // Reference: plain forward word copy of n words, addresses wrapping at 2^32
    task automatic model_copy(input logic [W-1:0] s, input logic [W-1:0] d, input int n);
        logic [W-1:0] sa;
        logic [W-1:0] da;
        logic [W-1:0] v;
        wr_t          e;
        for (int i = 0; i < n; i++) begin
            sa = s + W'(i);
            da = d + W'(i);
            v  = model_mem[sa[7:0]];
            model_mem[da[7:0]] = v;
            e.a = da;
            e.d = v;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every bus write and every done pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rst && !sb_off) begin
            if (we) begin
                wr_t e;
                checks++;
                if (!bus_gnt) begin
                    errors++;
                    $display("FAIL we_no_gnt: we=1 with bus_gnt=0 addr=%h", addr);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write: got addr=%h wd=%h expected no write", addr, wd);
                end else begin
                    e = exp_q.pop_front();
                    if (addr !== e.a || wd !== e.d) begin
                        errors++;
                        $display("FAIL bus_write: got addr=%h wd=%h expected addr=%h wd=%h",
                                 addr, wd, e.a, e.d);
                    end
                end
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_done: got done=1 expected none");
                end else begin
                    logic [CW-1:0] wl;
                    wl = done_q.pop_front();
                    if (words_left !== wl) begin
                        errors++;
                        $display("FAIL words_left: got %0d expected %0d", words_left, wl);
                    end
                end
                chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    // One transfer; cycle 0 is the cycle carrying the start pulse
    task automatic run(input logic [W-1:0] s, input logic [W-1:0] d, input int n,
                       input int exp_words, input int exp_done,
                       input int stall_lo, input int stall_hi, input int abort_cyc,
                       input bit rnd_gnt, input int clr_cyc);
        int cyc;
        bit seen;
        model_copy(s, d, exp_words);
        done_q.push_back(CW'(n - exp_words));
        @(posedge clk);
        #1;
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = CW'(n);
        abort    = (abort_cyc == 0);
        bus_gnt  = 1'b1;
        irq_clr  = 1'b0;
        cyc      = 0;
        seen     = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                start   = 1'b0;
                cyc++;
                abort   = (cyc == abort_cyc);
                irq_clr = (clr_cyc > 0) && (cyc >= clr_cyc);
                bus_gnt = rnd_gnt ? ($urandom_range(0, 3) != 0)
                                  : !((cyc >= stall_lo) && (cyc < stall_hi));
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        end
        if (exp_done >= 0) chk("done_cycle", 32'(cyc), 32'(exp_done));
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        abort   = 1'b0;
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("irq_set", 32'(irq), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        @(negedge clk);
        chk("irq_clear", 32'(irq), 32'd0);
    endtask

    initial begin
        int bad;
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        irq_clr  = 1'b0;
        bus_gnt  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i]       = $urandom;
            model_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_words_left", 32'(words_left), 32'd0);
        rst = 1'b1;

        // RAM to RAM, continuous grant; irq_clr held over the completion edge must lose
        poke(8'h10, 32'hAAAA_0001);
        poke(8'h11, 32'hBBBB_0002);
        poke(8'h12, 32'hCCCC_0003);
        poke(8'h13, 32'hDDDD_0004);
        run(32'h10, 32'h40, 4, 4, 10, 0, 0, -1, 1'b0, 9);
        chk("ram_40", mem[8'h40], 32'hAAAA_0001);
        chk("ram_41", mem[8'h41], 32'hBBBB_0002);
        chk("ram_42", mem[8'h42], 32'hCCCC_0003);
        chk("ram_43", mem[8'h43], 32'hDDDD_0004);

        // Zero length: no bus cycles, done right after FIN entry
        run(32'h10, 32'h60, 0, 0, 1, 0, 0, -1, 1'b0, 0);

        // Grant withdrawn for 3 cycles during the first write
        run(32'h10, 32'h48, 2, 2, 9, 3, 6, -1, 1'b0, 0);

        // RAM to PORT, then PIN to RAM
        poke(8'h20, 32'h0000_0005);
        run(32'h20, W'(PORT_ADDR), 1, 1, 4, 0, 0, -1, 1'b0, 0);
        chk("port_reg", mem[8'h81], 32'h0000_0005);
        poke(8'h82, 32'h0000_00A5);
        run(W'(PIN_ADDR), 32'h30, 1, 1, 4, 0, 0, -1, 1'b0, 0);
        chk("pin_sample", mem[8'h30], 32'h0000_00A5);

        // Abort in the second read: two words land, six remain
        run(32'h00, 32'h70, 8, 2, 6, 0, 0, 4, 1'b0, 0);
        // Abort while requesting: nothing moves
        run(32'h00, 32'h70, 5, 0, 2, 0, 0, 1, 1'b0, 0);
        // Abort together with start is ignored
        run(32'h08, 32'h78, 3, 3, 8, 0, 0, 0, 1'b0, 0);

        // Source and destination wrap past the top of the address space
        poke(8'hFF, 32'h1111_FFFF);
        poke(8'h00, 32'h2222_0000);
        run(32'hFFFF_FFFF, 32'h50, 2, 2, 6, 0, 0, -1, 1'b0, 0);
        chk("wrap_50", mem[8'h50], 32'h1111_FFFF);
        chk("wrap_51", mem[8'h51], 32'h2222_0000);
        run(32'h30, 32'hFFFF_FFFE, 3, 3, 8, 0, 0, -1, 1'b0, 0);

        // Randomized copies, including overlapping ranges, under random grant
        for (int t = 0; t < 24; t++) begin
            logic [W-1:0] s;
            logic [W-1:0] d;
            int           n;
            n = $urandom_range(0, 6);
            s = (t % 4 == 3) ? W'($urandom) : W'($urandom_range(0, 127));
            d = (t % 3 == 2) ? s + W'($urandom_range(1, 3)) : W'($urandom_range(0, 127));
            run(s, d, n, n, -1, 0, 0, -1, 1'b1, 0);
        end

        // Asynchronous reset in the middle of a write
        sb_off = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b1;
        src_addr = 32'h10;
        dst_addr = 32'h60;
        len      = CW'(4);
        bus_gnt  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_rst_we", 32'(we), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_we", 32'(we), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_req", 32'(bus_req), 32'd0);
        chk("async_rst_words", 32'(words_left), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
        sb_off = 1'b0;
        run(32'h10, 32'h64, 2, 2, 6, 0, 0, -1, 1'b0, 0);

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== model_mem[i]) bad++;
        end
        chk("mem_image", 32'(bad), 32'd0);
        chk("sb_drained", 32'(exp_q.size() + done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
